// File: rtl/ssd_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : ssd_bin2bcd_seq
// Description : Sequential binary-to-BCD converter for the seven-segment path.
//               Uses shift-and-add-3 (double dabble) and processes one input
//               bit per clock. Produces DIGITS packed BCD nibbles, which the
//               seven-segment driver scans onto the Nexys4DDR display.
//               The handshake is start/busy/done. Results stay stable between
//               conversions.
// Optional    : define SSD_LZ_BLANK_EN to add the blank_mask output, which
//               flags leading-zero digits.
// Ports       : clk        in  system clock, rising edge
//               rst        in  synchronous active-high reset
//               start      in  conversion request (accepted only when idle)
//               bin_in     in  unsigned binary value [BIN_W-1:0]
//               busy       out high while a conversion is in flight
//               done       out one-cycle pulse when bcd_out/overflow update
//               bcd_out    out packed BCD; digit i at [4i+3:4i]
//               overflow   out last accepted value exceeded 10^DIGITS-1
//               blank_mask out leading-zero mask (SSD_LZ_BLANK_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_bin2bcd_seq #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef SSD_LZ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_mask
`endif
);

    // Largest value that fits in DIGITS decimal digits. It is evaluated at
    // elaboration time, so the overflow test reduces to a constant compare.
    function automatic longint unsigned f_pow10(input int n);
        longint unsigned v;
        v = 1;
        for (int k = 0; k < n; k++) begin
            v = v * 10;
        end
        return v;
    endfunction

    localparam longint unsigned c_MAX_VAL  = f_pow10(DIGITS) - 1;
    localparam int              c_CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BIN_W - 1);
    localparam logic [4*DIGITS-1:0] c_ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [BIN_W-1:0]      r_shreg;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_ovf;

    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf_out;
    logic                  r_done;

    logic                  w_ovf_in;
    logic [4*DIGITS-1:0]   w_adj;

    assign w_ovf_in = (64'(bin_in) > c_MAX_VAL);

    // Add-3 correction on every scratch digit that is >= 5. The 4-bit add
    // never carries out for legal digits 5..9.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                    ? r_scratch[4*gi +: 4] + 4'd3
                                    : r_scratch[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg   <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= c_CNT_LOAD;
                        r_ovf     <= w_ovf_in;
                    end
                end
                S_SHIFT: begin
                    // Bits pushed past the top digit are dropped. That only
                    // happens for overflowing inputs, whose result is replaced.
                    r_scratch <= (4*DIGITS)'({w_adj, r_shreg[BIN_W-1]});
                    r_shreg   <= r_shreg << 1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result registers. DONE holds the finished scratch value. The outputs
    // and the done pulse load together on the edge that leaves DONE, so
    // bcd_out is already valid in the same cycle that done is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd     <= '0;
            r_ovf_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_bcd     <= r_ovf ? c_ALL_NINES : r_scratch;
                r_ovf_out <= r_ovf;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf_out;

`ifdef SSD_LZ_BLANK_EN
    logic [DIGITS-1:0] r_mask;
    logic [DIGITS-1:0] w_mask;

    // Digit i is blanked when it and every digit above it are zero. Digit 0
    // is never blanked, so a value of zero still shows a single "0".
    assign w_mask[0] = 1'b0;
    generate
        for (genvar gm = 1; gm < DIGITS; gm++) begin : g_mask
            assign w_mask[gm] = (r_scratch[4*DIGITS-1:4*gm] == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (r_state == S_DONE) begin
            r_mask <= r_ovf ? '0 : w_mask;
        end
    end

    assign blank_mask = r_mask;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ssd_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_bin2bcd_seq
// Description : Self-checking bench for ssd_bin2bcd_seq. Expected results are
//               computed arithmetically and queued at stimulus time. They are
//               popped and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_bin2bcd_seq;

    localparam int c_LAT = 28;

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  mask;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;
`ifdef SSD_LZ_BLANK_EN
    logic [7:0]  blank_mask;
`endif

    int   total;
    int   bad;
    exp_t sbq[$];

    ssd_bin2bcd_seq #(.DIGITS(8), .BIN_W(27)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
`ifdef SSD_LZ_BLANK_EN
        ,
        .blank_mask (blank_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [26:0] v);
        exp_t        e;
        int unsigned x;
        logic        allz;
        x     = 32'(v);
        e.ovf = (x > 32'd99999999);
        for (int d = 0; d < 8; d++) begin
            e.bcd[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        if (e.ovf) e.bcd = 32'h99999999;
        e.mask = '0;
        allz   = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            allz      = allz && (e.bcd[4*i +: 4] == 4'h0);
            e.mask[i] = allz;
        end
        if (e.ovf) e.mask = '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge (edge 0) and queue the expected result.
    task automatic start_conv(input logic [26:0] v);
        bin_in = v;
        start  = 1'b1;
        sbq.push_back(model(v));
        step();
        start  = 1'b0;
        bin_in = 27'($urandom);  // later changes must not matter
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Wait for done; 'already' edges have elapsed since edge 0.
    task automatic wait_done(input string tag, input int already, input int exp_lat);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = already;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
            chk({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({tag, "_bcd"}, 64'(bcd_out), 64'(e.bcd));
                chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
`ifdef SSD_LZ_BLANK_EN
                chk({tag, "_mask"}, 64'(blank_mask), 64'(e.mask));
`endif
            end
        end
    endtask

    // The done pulse lasts a single cycle and the result holds afterwards.
    task automatic check_pulse_hold(input string tag);
        logic [31:0] snap;
        snap = bcd_out;
        step();
        chk({tag, "_pulse1"}, 64'(done), 64'd0);
        repeat (4) step();
        chk({tag, "_hold"}, 64'(bcd_out), 64'(snap));
    endtask

    initial begin
        int  seen_cnt;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd_out), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'd0);
`ifdef SSD_LZ_BLANK_EN
        chk("rst_mask", 64'(blank_mask), 64'h0);
`endif
        rst = 1'b0;
        step();

        // Zero
        start_conv(27'd0);
        wait_done("zero", 0, c_LAT);
        check_pulse_hold("zero");

        // Mixed digits
        start_conv(27'd12345678);
        wait_done("mixed", 0, c_LAT);
        chk("mixed_const", 64'(bcd_out), 64'h12345678);
        check_pulse_hold("mixed");

        // Largest in-range value
        start_conv(27'd99999999);
        wait_done("max_ok", 0, c_LAT);
        chk("max_ok_ovf_const", 64'(overflow), 64'd0);
        check_pulse_hold("max_ok");

        // First overflowing value
        start_conv(27'd100000000);
        wait_done("ovf", 0, c_LAT);
        chk("ovf_const_bcd", 64'(bcd_out), 64'h99999999);
        chk("ovf_const_flag", 64'(overflow), 64'd1);
        check_pulse_hold("ovf");

        // Full-scale input
        start_conv(27'h7ffffff);
        wait_done("fullscale", 0, c_LAT);
        check_pulse_hold("fullscale");

        // A start that arrives while busy is ignored and does not queue
        start_conv(27'd42);
        repeat (4) step();
        start  = 1'b1;
        bin_in = 27'd7;
        step();
        start  = 1'b0;
        wait_done("ignore", 5, c_LAT);
        chk("ignore_const", 64'(bcd_out), 64'h00000042);
`ifdef SSD_LZ_BLANK_EN
        chk("mask42_const", 64'(blank_mask), 64'b11111100);
`endif
        seen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) seen_cnt++;
        end
        chk("ignore_no_second_done", 64'(seen_cnt), 64'd0);

        // Back-to-back: the next start is driven in the done cycle
        start_conv(27'd987654);
        wait_done("b2b_a", 0, c_LAT);
        start_conv(27'd13);
        wait_done("b2b_b", 0, c_LAT);
        check_pulse_hold("b2b");

        // Random values
        for (int r = 0; r < 4; r++) begin
            start_conv(27'($urandom_range(0, 99999999)));
            wait_done("rand", 0, c_LAT);
        end

        // A reset during a conversion aborts it
        start_conv(27'd555);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sbq.pop_back());
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_bcd", 64'(bcd_out), 64'h0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        seen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) seen_cnt++;
        end
        chk("abort_no_done", 64'(seen_cnt), 64'd0);
        chk("abort_bcd_stays", 64'(bcd_out), 64'h0);
        start_conv(27'd555);
        wait_done("after_abort", 0, c_LAT);
        chk("after_abort_const", 64'(bcd_out), 64'h00000555);

        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
